// File: rtl/spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_pkg : state encoding, SPI mode constants and width helpers           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  localparam bit CPOL_IDLE_LOW     = 1'b0;
  localparam bit CPOL_IDLE_HIGH    = 1'b1;
  localparam bit CPHA_SAMPLE_LEAD  = 1'b0;
  localparam bit CPHA_SAMPLE_TRAIL = 1'b1;

  // Toggle counter must hold 0..2*DATA_W inclusive.
  function automatic int tog_width(input int data_w);
    return $clog2(2 * data_w + 1);
  endfunction

  function automatic int cnt_width(input int clk_div);
    return (clk_div > 2) ? $clog2(clk_div) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_core_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_master_core_if : word handshake between upstream logic and the core  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface spi_master_core_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  busy
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_sclk_gen : half-period counter, toggle counter and sclk register     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter bit CPOL    = CPOL_IDLE_LOW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run_i,
  input  logic                         toggle_en_i,
  output logic                         sclk_o,
  output logic                         lead_pulse_o,
  output logic                         trail_pulse_o,
  output logic [tog_width(DATA_W)-1:0] toggle_idx_o,
  output logic                         last_toggle_o,
  output logic                         half_wrap_o
);

  localparam int                CNT_W    = cnt_width(CLK_DIV);
  localparam int                TOG_W    = tog_width(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLK_DIV - 1);
  localparam logic [TOG_W-1:0]  TOG_LAST = TOG_W'(2 * DATA_W);

  logic [CNT_W-1:0] cnt_q;
  logic [TOG_W-1:0] tog_q;
  logic             sclk_q;
  logic             toggle;

  // Pulses are combinational so the core acts on the same edge that toggles sclk.
  always_comb begin
    half_wrap_o   = run_i && (cnt_q == CNT_MAX);
    toggle        = half_wrap_o && toggle_en_i;
    toggle_idx_o  = tog_q + TOG_W'(1);
    lead_pulse_o  = toggle && toggle_idx_o[0];
    trail_pulse_o = toggle && !toggle_idx_o[0];
    last_toggle_o = toggle && (toggle_idx_o == TOG_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tog_q  <= '0;
      sclk_q <= CPOL;
    end else if (!run_i) begin
      cnt_q  <= '0;
      tog_q  <= '0;
      sclk_q <= CPOL;
    end else begin
      cnt_q <= half_wrap_o ? '0 : cnt_q + CNT_W'(1);
      if (toggle) begin
        sclk_q <= ~sclk_q;
        tog_q  <= toggle_idx_o;
      end
    end
  end

  assign sclk_o = sclk_q;

endmodule
`default_nettype wire

// File: rtl/spi_master_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_master_core : byte SPI master; build macro SPI_MASTER_LOOPBACK_EN    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_master_core
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter bit CPOL    = CPOL_IDLE_LOW,
  parameter bit CPHA    = CPHA_SAMPLE_LEAD
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_master_core_if.slave bus,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             cs_n
);

  localparam int TOG_W = tog_width(DATA_W);

  spi_state_e        state_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_sh_d;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              mosi_q;
  logic              cs_n_q;

  logic              miso_int;
  logic              lead_pulse;
  logic              trail_pulse;
  logic              last_toggle;
  logic              half_wrap;
  logic              sample_en;
  logic              shift_en;
  logic [TOG_W-1:0]  toggle_idx;

`ifdef SPI_MASTER_LOOPBACK_EN
  // External pin is intentionally disconnected in the loopback build.
  assign miso_int = mosi_q;
`else
  assign miso_int = miso;
`endif

  spi_sclk_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_sclk_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .run_i         (state_q != ST_IDLE),
    .toggle_en_i   ((state_q == ST_SETUP) || (state_q == ST_SHIFT)),
    .sclk_o        (sclk),
    .lead_pulse_o  (lead_pulse),
    .trail_pulse_o (trail_pulse),
    .toggle_idx_o  (toggle_idx),
    .last_toggle_o (last_toggle),
    .half_wrap_o   (half_wrap)
  );

  // The first bit is already on mosi at accept, so the first shift edge is skipped.
  generate
    if (CPHA == CPHA_SAMPLE_TRAIL) begin : g_cpha1
      assign sample_en = trail_pulse;
      assign shift_en  = lead_pulse && (toggle_idx != TOG_W'(1));
    end else begin : g_cpha0
      assign sample_en = lead_pulse;
      assign shift_en  = trail_pulse && (toggle_idx != TOG_W'(2 * DATA_W));
    end
  endgenerate

  always_comb begin
    tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
    rx_sh_d = {rx_sh_q[DATA_W-2:0], miso_int};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.tx_valid) begin
            tx_sh_q <= bus.tx_data;
            rx_sh_q <= '0;
            mosi_q  <= bus.tx_data[DATA_W-1];
            cs_n_q  <= 1'b0;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP, ST_SHIFT: begin
          if (sample_en) begin
            rx_sh_q <= rx_sh_d;
          end
          if (shift_en) begin
            tx_sh_q <= tx_sh_d;
            mosi_q  <= tx_sh_d[DATA_W-1];
          end
          if ((state_q == ST_SETUP) && lead_pulse) begin
            state_q <= ST_SHIFT;
          end
          if (last_toggle) begin
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (half_wrap) begin
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rx_data_q  <= rx_sh_q;
            rx_valid_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_ready = (state_q == ST_IDLE);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign mosi         = mosi_q;
  assign cs_n         = cs_n_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_master_core : directed bench, mode-0 and mode-3 cores with slaves |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_spi_master_core;

  localparam int DW = 8;
  localparam int CD = 4;
`ifdef SPI_MASTER_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_core_if #(.DATA_W(DW)) bus0 ();
  spi_master_core_if #(.DATA_W(DW)) bus3 ();

  logic sclk0, mosi0, cs0;
  logic sclk3, mosi3, cs3;
  logic miso0 = 1'b0;
  logic miso3 = 1'b0;

  spi_master_core #(.DATA_W(DW), .CLK_DIV(CD), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .sclk(sclk0), .mosi(mosi0), .miso(miso0), .cs_n(cs0)
  );

  spi_master_core #(.DATA_W(DW), .CLK_DIV(CD), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3),
    .sclk(sclk3), .mosi(mosi3), .miso(miso3), .cs_n(cs3)
  );

  // Slave models: mode 0 changes miso on falling sclk, mode 3 on falling (leading) sclk.
  logic [7:0] sl0 = 8'h00, sl0_sh = 8'h00, cap0 = 8'h00;
  logic [7:0] sl3 = 8'h00, sl3_sh = 8'h00, cap3 = 8'h00;
  int sl0_idx = 0, sl3_idx = 0;

  always @(negedge cs0) begin
    sl0_sh  = sl0;
    miso0   = sl0[7];
    sl0_idx = 1;
    cap0    = 8'h00;
  end
  always @(negedge sclk0) if (cs0 === 1'b0 && sl0_idx < 8) begin
    miso0   = sl0_sh[7-sl0_idx];
    sl0_idx = sl0_idx + 1;
  end
  always @(posedge sclk0) if (cs0 === 1'b0) cap0 = {cap0[6:0], mosi0};

  always @(negedge cs3) begin
    sl3_sh  = sl3;
    sl3_idx = 0;
    cap3    = 8'h00;
  end
  always @(negedge sclk3) if (cs3 === 1'b0 && sl3_idx < 8) begin
    miso3   = sl3_sh[7-sl3_idx];
    sl3_idx = sl3_idx + 1;
  end
  always @(posedge sclk3) if (cs3 === 1'b0) cap3 = {cap3[6:0], mosi3};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_rx(input logic [7:0] sent, input logic [7:0] slave);
    return LOOPBACK ? sent : slave;
  endfunction

  // Issue one word and run until rx_valid (or a 200-cycle bound).
  task automatic xfer(input bit m3, input logic [7:0] d,
                      output int cyc, output int ftog, output int cslow);
    logic rv, cs, sc;
    if (m3) begin
      bus3.tx_data = d; bus3.tx_valid = 1'b1;
    end else begin
      bus0.tx_data = d; bus0.tx_valid = 1'b1;
    end
    tick();
    bus0.tx_valid = 1'b0;
    bus3.tx_valid = 1'b0;
    cyc = 0; ftog = -1; cslow = 0;
    forever begin
      rv = m3 ? bus3.rx_valid : bus0.rx_valid;
      cs = m3 ? cs3 : cs0;
      sc = m3 ? sclk3 : sclk0;
      if (ftog < 0 && sc !== m3) ftog = cyc;
      if (rv === 1'b1 || cyc >= 200) break;
      if (cs === 1'b0) cslow++;
      tick();
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ftog, cslow, hi, seen;
    bus0.tx_data = 8'h00; bus0.tx_valid = 1'b0;
    bus3.tx_data = 8'h00; bus3.tx_valid = 1'b0;

    // Reset values, during and after reset.
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_cs_n",     cs0, 1);
    check("rst_sclk0",    sclk0, 0);
    check("rst_sclk3",    sclk3, 1);
    check("rst_mosi",     mosi0, 0);
    check("rst_rx_data",  bus0.rx_data, 0);
    check("rst_rx_valid", bus0.rx_valid, 0);
    check("rst_busy",     bus0.busy, 0);
    check("rst_tx_ready", bus0.tx_ready, 1);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_cs_n",     cs0, 1);
    check("idle_tx_ready", bus0.tx_ready, 1);
    check("idle_cs3_n",    cs3, 1);

    // Mode 0: send 0xA5, slave answers 0x3C.
    sl0 = 8'h3C;
    xfer(1'b0, 8'hA5, cyc, ftog, cslow);
    check("m0_latency",   cyc, 68);
    check("m0_first_tog", ftog, CD);
    check("m0_cs_low",    cslow, 68);
    check("m0_rx_data",   bus0.rx_data, exp_rx(8'hA5, 8'h3C));
    check("m0_mosi_bits", cap0, 8'hA5);
    check("m0_cs_end",    cs0, 1);
    check("m0_sclk_end",  sclk0, 0);
    check("m0_mosi_end",  mosi0, 0);
    check("m0_busy_end",  bus0.busy, 0);
    tick();
    check("m0_strobe_1cyc", bus0.rx_valid, 0);
    check("m0_rx_hold",     bus0.rx_data, exp_rx(8'hA5, 8'h3C));

    // CPOL=1 CPHA=1: send 0x81, slave answers 0x7E.
    sl3 = 8'h7E;
    xfer(1'b1, 8'h81, cyc, ftog, cslow);
    check("m3_latency",   cyc, 68);
    check("m3_first_tog", ftog, CD);
    check("m3_rx_data",   bus3.rx_data, exp_rx(8'h81, 8'h7E));
    check("m3_mosi_bits", cap3, 8'h81);
    check("m3_sclk_idle", sclk3, 1);
    check("m3_cs_end",    cs3, 1);

    // Back-to-back with tx_valid held; tx_data changes while busy are ignored.
    sl0 = 8'h11;
    bus0.tx_data = 8'h01; bus0.tx_valid = 1'b1;
    tick();
    check("b2b_cs_low1", cs0, 0);
    sl0 = 8'h22;
    bus0.tx_data = 8'h02;
    cyc = 0;
    while (bus0.rx_valid !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    check("b2b_lat1",  cyc, 68);
    check("b2b_rx1",   bus0.rx_data, exp_rx(8'h01, 8'h11));
    check("b2b_mosi1", cap0, 8'h01);
    hi = 0;
    while (cs0 === 1'b1 && hi < 10) begin hi++; tick(); end
    check("b2b_cs_gap", hi, 1);
    bus0.tx_valid = 1'b0;
    cyc = 0;
    while (bus0.rx_valid !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    check("b2b_lat2",  cyc, 68);
    check("b2b_rx2",   bus0.rx_data, exp_rx(8'h02, 8'h22));
    check("b2b_mosi2", cap0, 8'h02);
    tick();

    // Reset asserted right after toggle 7.
    sl0 = 8'h3C;
    bus0.tx_data = 8'h5A; bus0.tx_valid = 1'b1;
    tick();
    bus0.tx_valid = 1'b0;
    repeat (7 * CD) tick();
    check("mid_sclk_t7", sclk0, 1);
    rst_n = 1'b0;
    #1;
    check("mid_cs_n",     cs0, 1);
    check("mid_sclk",     sclk0, 0);
    check("mid_mosi",     mosi0, 0);
    check("mid_busy",     bus0.busy, 0);
    check("mid_tx_ready", bus0.tx_ready, 1);
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (80) begin
      tick();
      if (bus0.rx_valid === 1'b1 || cs0 !== 1'b1) seen++;
    end
    check("mid_no_rx_valid", seen, 0);
    check("mid_rx_data",     bus0.rx_data, 0);

    sl0 = 8'h96;
    xfer(1'b0, 8'h69, cyc, ftog, cslow);
    check("post_rst_lat",  cyc, 68);
    check("post_rst_rx",   bus0.rx_data, exp_rx(8'h69, 8'h96));
    check("post_rst_mosi", cap0, 8'h69);

    // miso held low by the slave: loopback build returns the sent word.
    sl0 = 8'h00;
    xfer(1'b0, 8'hC3, cyc, ftog, cslow);
    check("lb_lat", cyc, 68);
    check("lb_rx",  bus0.rx_data, exp_rx(8'hC3, 8'h00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master_core.md
# spi_master_core

Byte-oriented SPI master that serialises parallel words onto `sclk`/`mosi`/`cs_n` and captures `miso` into a parallel word. It is clocked from the divided PLL output (`clkoutd` of `Gowin_rPLL`, 20.25 MHz) and is the first consumer of that clock. Upstream logic hands it words through a valid/ready handshake. It returns received words as a one-cycle strobe.

## Interface
- `DATA_W`, default 8: bits per transfer, MSB first.
- `CLK_DIV`, default 4: `clk` cycles per SCLK half-period. Legal range ≥2. `sclk` = `clk`/(2·`CLK_DIV`).
- `CPOL`, default 0: idle level of `sclk`.
- `CPHA`, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.

Ports:
- `clk` input 1: core clock, `clkoutd`.
- `rst_n` input 1: asynchronous active-low reset.
- `tx_data` input `DATA_W`: word to send.
- `tx_valid` input 1: `tx_data` valid.
- `tx_ready` output 1: high only in IDLE (combinational from state).
- `rx_data` output `DATA_W`: last received word. Held until the next completion.
- `rx_valid` output 1: one-cycle completion strobe.
- `busy` output 1: high whenever state ≠ IDLE.
- `sclk` output 1: SPI clock.
- `mosi` output 1: serial data out.
- `miso` input 1: serial data in.
- `cs_n` output 1: chip select, active low.

## Operation
- **States:**
  - IDLE → SETUP on `tx_valid && tx_ready`.
  - SETUP → SHIFT after `CLK_DIV` cycles.
  - SHIFT → HOLD after 2·`DATA_W` SCLK toggles.
  - HOLD → IDLE after `CLK_DIV` cycles.
- **On accept:** `tx_data` latched into the shift register. `cs_n`←0. `mosi` = shift register MSB.
- **Half-period counter:** counts 0..`CLK_DIV`-1, wraps. Every wrap in SETUP-end/SHIFT toggles `sclk`. Toggles are numbered 1..2·`DATA_W`; odd toggles are leading edges, even toggles are trailing edges.
- **`CPHA`=0:**
  - Sample `miso` on odd toggles.
  - Shift on even toggles 2..2·`DATA_W`-2.
- **`CPHA`=1:**
  - Shift on odd toggles 3..2·`DATA_W`-1.
  - Sample on even toggles.
- **Sampling:** `miso` is registered on the same `clk` edge that registers the `sclk` toggle. Sampled bits shift in at the LSB.
- **End of HOLD (single registered update):** `cs_n`←1, `mosi`←0, `rx_data`←captured word, `rx_valid`←1, state←IDLE.
- **Back-to-back transfers:** `tx_valid` held high is accepted in the first IDLE cycle. `cs_n` is then high for exactly 1 cycle between words.
- **Input sampling:** `tx_data` changes while busy are ignored. `tx_valid` while busy is not accepted and not lost; upstream holds it.

## Timing
- **Reset values:** `cs_n`=1, `sclk`=`CPOL`, `mosi`=0, `rx_data`=0, `rx_valid`=0, `busy`=0, `tx_ready`=1.
- **Accept edge = E0.** `cs_n` low and `busy` high from E0.
- **First `sclk` toggle:** E0+`CLK_DIV`.
- **Last toggle:** E0+2·`DATA_W`·`CLK_DIV`. `sclk` is back at `CPOL` after it.
- **Completion:** `cs_n` rises and `rx_valid` asserts at E0+(2·`DATA_W`+1)·`CLK_DIV`. This is 68 cycles for the defaults.
- **Reset mid-transfer:** immediate (asynchronous) return to reset values. No `rx_valid`. The partial word is discarded.

## Configuration
- **`SPI_MASTER_LOOPBACK_EN` defined:** internal `miso` is replaced by the registered `mosi`, and the external `miso` is ignored. `rx_data` equals the transmitted word for both `CPHA` values.
- **Undefined:** external `miso` is used. This is the production build.

## Structure
- **`spi_pkg`:** state encoding (IDLE/SETUP/SHIFT/HOLD) and the `CPOL`/`CPHA` mode constants.
- **Sub-module `spi_sclk_gen`:**
  - Contains the half-period counter, toggle counter and `sclk` register.
  - Outputs `lead_pulse`, `trail_pulse`, `toggle_idx` and `last_toggle`.
- **`spi_master_core`:** owns the FSM, shift register, `cs_n` and the handshake.

## Test plan
- **Mode 0 reset/idle:** with `rst_n` released, outputs hold reset values and `tx_ready`=1.
- **Mode 0 transfer, slave model returns 0x3C:** send 0xA5 → `mosi` bits 1,0,1,0,0,1,0,1 sampled on `sclk` rising edges; `cs_n` low for 68 cycles; `rx_valid` strobe with `rx_data`=0x3C.
- **`CPOL`=1, `CPHA`=1, send 0x81 with slave returning 0x7E:** `sclk` idles high, data changes on falling edges, `rx_data`=0x7E.
- **Back-to-back 0x01, 0x02 with `tx_valid` held:** `cs_n` high exactly 1 cycle between words, both words received in order.
- **`rst_n` low at toggle 7:** `cs_n`=1 and `sclk`=`CPOL` immediately; no `rx_valid`; the next transfer completes normally.
- **`SPI_MASTER_LOOPBACK_EN`, send 0xC3 with `miso` tied 0:** `rx_data`=0xC3.
